// File: rtl/mc_pkg.sv
// mc_pkg: shared constants and types for the multi-cycle controller.
// Holds RV32I opcode constants, imm_sel/alu_sel/wb_sel encodings, the
// instruction class enumeration and the FSM state enumeration.
// The TRAP state exists only when MC_ILLEGAL_TRAP_EN is defined.
package mc_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_SLL   = 4'd2;
   localparam logic [3:0] ALU_SLT   = 4'd3;
   localparam logic [3:0] ALU_SLTU  = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_OR    = 4'd8;
   localparam logic [3:0] ALU_AND   = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   localparam logic [1:0] WB_MEM = 2'b00;
   localparam logic [1:0] WB_ALU = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   typedef enum logic [3:0] {
      CL_OP, CL_OP_IMM, CL_LUI, CL_AUIPC, CL_JAL, CL_JALR,
      CL_BRANCH, CL_LOAD, CL_STORE, CL_ILLEGAL
   } cls_e;

`ifdef MC_ILLEGAL_TRAP_EN
   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_e;
`else
   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_e;
`endif

   // alt selects SUB for funct3=000 and SRA for funct3=101
   function automatic logic [3:0] alu_of_f3(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational instruction classifier.
// Ports: opcode_i/funct3_i/funct7b5_i instruction fields in;
//        cls_o instruction class, imm_sel_o immediate format, alu_sel_o ALU op out.
module mc_decode
   import mc_pkg::*;
(
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   output cls_e       cls_o,
   output logic [2:0] imm_sel_o,
   output logic [3:0] alu_sel_o
);

   always_comb begin
      cls_o = CL_ILLEGAL;
      case (opcode_i)
         OPC_OP:     cls_o = CL_OP;
         OPC_OP_IMM: cls_o = CL_OP_IMM;
         OPC_LUI:    cls_o = CL_LUI;
         OPC_AUIPC:  cls_o = CL_AUIPC;
         OPC_JAL:    cls_o = CL_JAL;
         OPC_JALR:   cls_o = CL_JALR;
         OPC_BRANCH: cls_o = CL_BRANCH;
         OPC_LOAD:   cls_o = CL_LOAD;
         OPC_STORE:  cls_o = CL_STORE;
         default:    cls_o = CL_ILLEGAL;
      endcase
   end

   assign imm_sel_o = cls_o == CL_STORE  ? IMM_S :
                      cls_o == CL_BRANCH ? IMM_B :
                      cls_o inside {CL_LUI, CL_AUIPC} ? IMM_U :
                      cls_o == CL_JAL    ? IMM_J : IMM_I;

   // Immediate forms have no SUB; funct7[5] only selects SRA for shifts there.
   // Loads, stores, branches, jumps and AUIPC all use the adder for addresses.
   assign alu_sel_o = cls_o == CL_OP     ? alu_of_f3(funct3_i, funct7b5_i) :
                      cls_o == CL_OP_IMM ? alu_of_f3(funct3_i, funct7b5_i && funct3_i == 3'b101) :
                      cls_o == CL_LUI    ? ALU_PASSB : ALU_ADD;

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB[/TRAP]).
// Ports: clk, rst_n (async, active-low); inst_i/inst_valid_i/inst_ready_o fetch
//        handshake; br_eq_i/br_lt_i branch compare; mem_ready_i/mem_req_o/mem_rw_o
//        data memory; imm_sel_o, alu_sel_o, a_sel_o, b_sel_o, wb_sel_o datapath
//        selects; reg_wen_o, pc_wen_o, pc_sel_o write enables; mem_err_o timeout
//        pulse; illegal_o sticky illegal-opcode flag.
// Parameter MEM_WAIT_MAX: MEM cycles without mem_ready before the access aborts.
// Macro MC_ILLEGAL_TRAP_EN: illegal opcodes trap forever instead of acting as NOP.
module mc_control
   import mc_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] inst_i,
   input  logic        inst_valid_i,
   output logic        inst_ready_o,
   input  logic        br_eq_i,
   input  logic        br_lt_i,
   input  logic        mem_ready_i,
   output logic [2:0]  imm_sel_o,
   output logic [3:0]  alu_sel_o,
   output logic        a_sel_o,
   output logic        b_sel_o,
   output logic        mem_req_o,
   output logic        mem_rw_o,
   output logic [1:0]  wb_sel_o,
   output logic        reg_wen_o,
   output logic        pc_wen_o,
   output logic        pc_sel_o,
   output logic        mem_err_o,
   output logic        illegal_o
);

   localparam int CW = $clog2(MEM_WAIT_MAX + 1);

   state_e          state_q, state_d;
   logic [31:0]     ir_q, ir_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            run_q, err_q, timeout, active, br_take;
   cls_e            cls;
   logic [2:0]      imm_sel;
   logic [3:0]      alu_sel;

   mc_decode u_decode (
      .opcode_i   (ir_q[6:0]),
      .funct3_i   (ir_q[14:12]),
      .funct7b5_i (ir_q[30]),
      .cls_o      (cls),
      .imm_sel_o  (imm_sel),
      .alu_sel_o  (alu_sel)
   );

   // funct3[2] picks lt over eq, funct3[0] inverts (BNE/BGE/BGEU)
   assign br_take = (ir_q[14] ? br_lt_i : br_eq_i) ^ ir_q[12];

   // Datapath selects are only meaningful while an instruction is in flight
   assign active    = state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB};
   assign imm_sel_o = active ? imm_sel : IMM_I;
   assign alu_sel_o = active ? alu_sel : ALU_ADD;
   assign a_sel_o   = active && cls inside {CL_AUIPC, CL_JAL, CL_BRANCH};
   assign b_sel_o   = active && !(cls inside {CL_OP, CL_ILLEGAL});
   assign wb_sel_o  = !active || cls == CL_LOAD ? WB_MEM :
                      cls inside {CL_JAL, CL_JALR} ? WB_PC4 : WB_ALU;
   assign mem_err_o = err_q;

   always_comb begin
      state_d      = state_q;
      ir_d         = ir_q;
      inst_ready_o = 1'b0;
      pc_wen_o     = 1'b0;
      pc_sel_o     = 1'b0;
      reg_wen_o    = 1'b0;
      mem_req_o    = 1'b0;
      mem_rw_o     = 1'b0;
      timeout      = 1'b0;
      case (state_q)
         S_FETCH: begin
            // run_q holds inst_ready low until the first clock after reset
            inst_ready_o = run_q;
            if (run_q && inst_valid_i) begin
               ir_d    = inst_i;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (cls == CL_ILLEGAL) begin
`ifdef MC_ILLEGAL_TRAP_EN
               state_d = S_TRAP;
`else
               pc_wen_o = 1'b1;
               state_d  = S_FETCH;
`endif
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (cls == CL_BRANCH) begin
               pc_wen_o = 1'b1;
               pc_sel_o = br_take;
               state_d  = S_FETCH;
            end else begin
               state_d = cls inside {CL_LOAD, CL_STORE} ? S_MEM : S_WB;
            end
         end
         S_MEM: begin
            mem_req_o = 1'b1;
            mem_rw_o  = cls == CL_STORE;
            // A completing access takes priority over the final wait cycle
            if (mem_ready_i) begin
               pc_wen_o = cls == CL_STORE;
               state_d  = cls == CL_STORE ? S_FETCH : S_WB;
            end else if (cnt_q == CW'(MEM_WAIT_MAX - 1)) begin
               timeout = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_WB: begin
            reg_wen_o = ir_q[11:7] != 5'd0;
            pc_wen_o  = 1'b1;
            pc_sel_o  = cls inside {CL_JAL, CL_JALR};
            state_d   = S_FETCH;
         end
`ifdef MC_ILLEGAL_TRAP_EN
         S_TRAP: state_d = S_TRAP;
`endif
         default: state_d = S_FETCH;
      endcase
      cnt_d = (state_q == S_MEM && !mem_ready_i && !timeout) ? cnt_q + 1'b1 : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         ir_q    <= '0;
         cnt_q   <= '0;
         run_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         cnt_q   <= cnt_d;
         run_q   <= 1'b1;
         err_q   <= timeout;
      end
   end

`ifdef MC_ILLEGAL_TRAP_EN
   logic illegal_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) illegal_q <= 1'b0;
      else        illegal_q <= illegal_q | (state_q == S_DECODE && cls == CL_ILLEGAL);
   end

   assign illegal_o = illegal_q;
`else
   assign illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: scoreboard bench for mc_control; per-instruction expectations
// are queued when an instruction is issued and checked when it retires.
module tb_mc_control;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] inst = '0;
   logic        inst_valid = 1'b0, br_eq = 1'b0, br_lt = 1'b0, mem_ready = 1'b0;
   logic        inst_ready, a_sel, b_sel, mem_req, mem_rw, reg_wen, pc_wen, pc_sel, mem_err, illegal;
   logic [2:0]  imm_sel;
   logic [3:0]  alu_sel;
   logic [1:0]  wb_sel;
   logic [18:0] outs;

   typedef struct {
      int lat, pcw, pcs, nrw, rwc, nreq, mrw, imm, bs, wb, err;
   } exp_t;

   exp_t q[$];
   int   n_tot = 0, n_bad = 0, retired = 0;

   always #5 clk = ~clk;

   mc_control #(.MEM_WAIT_MAX(16)) dut (
      .clk(clk), .rst_n(rst_n), .inst_i(inst), .inst_valid_i(inst_valid), .inst_ready_o(inst_ready),
      .br_eq_i(br_eq), .br_lt_i(br_lt), .mem_ready_i(mem_ready), .imm_sel_o(imm_sel),
      .alu_sel_o(alu_sel), .a_sel_o(a_sel), .b_sel_o(b_sel), .mem_req_o(mem_req), .mem_rw_o(mem_rw),
      .wb_sel_o(wb_sel), .reg_wen_o(reg_wen), .pc_wen_o(pc_wen), .pc_sel_o(pc_sel),
      .mem_err_o(mem_err), .illegal_o(illegal)
   );

   assign outs = {inst_ready, imm_sel, alu_sel, a_sel, b_sel, mem_req, mem_rw, wb_sel,
                  reg_wen, pc_wen, pc_sel, mem_err, illegal};

   task automatic chk(input string tag, input int got, input int exp);
      n_tot++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic exp_t mk(input int lat, pcw, pcs, nrw, rwc, nreq, mrw, imm, bs, wb, err);
      exp_t e;
      e.lat = lat; e.pcw = pcw; e.pcs = pcs; e.nrw = nrw; e.rwc = rwc; e.nreq = nreq;
      e.mrw = mrw; e.imm = imm; e.bs = bs; e.wb = wb; e.err = err;
      return e;
   endfunction

   // Retirement monitor: cycle 1 is the FETCH cycle of the handshake
   initial begin
      bit act = 0;
      int cyc = 0, nreq = 0, nrw = 0, rwc = 0, mrw = 0, imm = 0, bs = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            act = 0;
         end else if (act) begin
            cyc++;
            if (mem_req) nreq++;
            if (mem_rw) mrw = 1;
            if (reg_wen) begin nrw++; rwc = cyc; end
            if (cyc == 2) begin imm = int'(imm_sel); bs = int'(b_sel); end
            if (pc_wen || mem_err) begin
               act = 0;
               if (q.size() == 0) begin
                  chk("sb_empty", 1, 0);
               end else begin
                  e = q.pop_front();
                  chk("latency", cyc, e.lat);
                  chk("pc_wen", int'(pc_wen), e.pcw);
                  chk("pc_sel", int'(pc_sel), e.pcs);
                  chk("reg_wen_cnt", nrw, e.nrw);
                  chk("reg_wen_cyc", rwc, e.rwc);
                  chk("mem_req_cyc", nreq, e.nreq);
                  chk("mem_rw", mrw, e.mrw);
                  chk("mem_err", int'(mem_err), e.err);
                  if (e.imm >= 0) chk("imm_sel", imm, e.imm);
                  if (e.bs >= 0) chk("b_sel", bs, e.bs);
                  if (e.wb >= 0) chk("wb_sel", int'(wb_sel), e.wb);
               end
               retired++;
            end
         end else if (inst_ready && inst_valid) begin
            act = 1; cyc = 1; nreq = 0; nrw = 0; rwc = 0; mrw = 0; imm = 0; bs = 0;
         end
      end
   end

   task automatic present(input logic [31:0] ins);
      int k = 0;
      @(posedge clk); #2;
      while (!inst_ready && k < 40) begin @(posedge clk); #2; k++; end
      if (!inst_ready) chk("fetch_ready_wait", 0, 1);
      inst = ins;
      inst_valid = 1'b1;
      @(posedge clk); #2;
      inst_valid = 1'b0;
   endtask

   // w = number of mem_ready=0 cycles before completion; -1 never completes
   task automatic run(input logic [31:0] ins, input int w, input logic eq, input logic lt, input exp_t e);
      int r0 = retired, wc = 0;
      q.push_back(e);
      br_eq = eq;
      br_lt = lt;
      present(ins);
      for (int c = 0; c < 100 && retired == r0; c++) begin
         if (mem_req) begin mem_ready = (wc == w); wc++; end
         else mem_ready = 1'b0;
         @(posedge clk); #2;
      end
      mem_ready = 1'b0;
      if (retired == r0) begin
         chk("retire_wait", 0, 1);
         $display("test done: total=%0d bad=%0d", n_tot, n_bad);
         $finish;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog total=%0d bad=%0d", n_tot, n_bad);
      $fatal(1);
   end

   initial begin
      #3;
      chk("rst_outs", int'(outs), 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready_before_clk", int'(inst_ready), 0);
      @(negedge clk);
      chk("rst_ready_after_clk", int'(inst_ready), 1);
      chk("rst_imm_sel", int'(imm_sel), 0);

      run(32'h00500093, 0, 0, 0, mk(4, 1, 0, 1, 4, 0, 0, 0, 1, 1, 0));    // addi x1,x0,5
      run(32'h00112223, 3, 0, 0, mk(7, 1, 0, 0, 0, 4, 1, 1, 1, -1, 0));   // sw, 3 waits
      run(32'h00112223, 0, 0, 0, mk(4, 1, 0, 0, 0, 1, 1, 1, 1, -1, 0));   // sw, no wait
      run(32'h00000463, 0, 1, 0, mk(3, 1, 1, 0, 0, 0, 0, 2, 1, -1, 0));   // beq taken
      run(32'h00000463, 0, 0, 0, mk(3, 1, 0, 0, 0, 0, 0, 2, 1, -1, 0));   // beq not taken
      run(32'h00001463, 0, 0, 0, mk(3, 1, 1, 0, 0, 0, 0, 2, 1, -1, 0));   // bne taken
      run(32'h00004463, 0, 0, 1, mk(3, 1, 1, 0, 0, 0, 0, 2, 1, -1, 0));   // blt taken
      run(32'h00005463, 0, 0, 1, mk(3, 1, 0, 0, 0, 0, 0, 2, 1, -1, 0));   // bge not taken
      run(32'h0000A283, 2, 0, 0, mk(7, 1, 0, 1, 7, 3, 0, 0, 1, 0, 0));    // lw, 2 waits
      run(32'h0000A283, 15, 0, 0, mk(20, 1, 0, 1, 20, 16, 0, 0, 1, 0, 0)); // ready on last cycle
      run(32'h0000A283, -1, 0, 0, mk(20, 0, 0, 0, 0, 16, 0, 0, 1, -1, 1)); // timeout
      @(negedge clk);
      chk("err_one_cycle", int'(mem_err), 0);
      chk("err_mem_req", int'(mem_req), 0);
      run(32'h123451B7, 0, 0, 0, mk(4, 1, 0, 1, 4, 0, 0, 3, 1, 1, 0));    // lui x3
      run(32'h010000EF, 0, 0, 0, mk(4, 1, 1, 1, 4, 0, 0, 4, 1, 2, 0));    // jal x1,+16
      run(32'h00208033, 0, 0, 0, mk(4, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));    // add x0 (no write)

      // Reset in the middle of a store's MEM phase
      present(32'h00112223);
      repeat (4) @(posedge clk);
      #2;
      chk("mid_mem_req_before", int'(mem_req), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_mem_req_async", int'(mem_req), 0);
      chk("mid_mem_outs", int'(outs), 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("mid_ready_before_clk", int'(inst_ready), 0);
      @(negedge clk);
      chk("mid_ready_after_clk", int'(inst_ready), 1);
      chk("mid_imm_sel", int'(imm_sel), 0);
      chk("mid_mem_req_after", int'(mem_req), 0);
      run(32'h00500093, 0, 0, 0, mk(4, 1, 0, 1, 4, 0, 0, 0, 1, 1, 0));

`ifdef MC_ILLEGAL_TRAP_EN
      present(32'h00000000);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("trap_illegal", int'(illegal), 1);
      chk("trap_ready", int'(inst_ready), 0);
      chk("trap_pc_wen", int'(pc_wen), 0);
      repeat (10) @(negedge clk);
      chk("trap_illegal_held", int'(illegal), 1);
      chk("trap_ready_held", int'(inst_ready), 0);
`else
      run(32'h00000000, 0, 0, 0, mk(2, 1, 0, 0, 0, 0, 0, -1, -1, -1, 0)); // NOP
      @(negedge clk);
      chk("nop_illegal", int'(illegal), 0);
      chk("nop_ready", int'(inst_ready), 1);
`endif
      chk("sb_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter MEM_WAIT_MAX, default 16, meaning max cycles in MEM awaiting mem_ready before abort.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 inst  input  32  fetched instruction word, valid when inst_valid=1.
REQ-005 inst_valid  input  1  fetch unit offers an instruction.
REQ-006 inst_ready  output  1  controller accepts inst; high only in FETCH.
REQ-007 br_eq, br_lt  input  1 each  branch comparator results, sampled in EXEC.
REQ-008 mem_ready  input  1  data memory completes current access.
REQ-009 imm_sel  output  3  I=000, S=001, B=010, U=011, J=100; drives the immediate generator.
REQ-010 alu_sel  output  4  ALU operation code.
REQ-011 a_sel, b_sel  output  1 each  ALU operand mux selects (a: 0=rs1, 1=PC; b: 0=rs2, 1=imm).
REQ-012 mem_req, mem_rw  output  1 each  memory request; rw 1=write.
REQ-013 wb_sel  output  2  writeback source: 00=mem, 01=ALU, 10=PC+4.
REQ-014 reg_wen, pc_wen, pc_sel  output  1 each  register write, PC update, PC source (1=ALU).
REQ-015 mem_err  output  1  one-cycle pulse on MEM timeout.
REQ-016 illegal  output  1  sticky illegal-opcode flag.

Function
REQ-017 FSM states: FETCH, DECODE, EXEC, MEM, WB, TRAP; all outputs Moore, decoded from state plus latched instruction register.
REQ-018 FETCH: inst_ready=1; on inst_valid=1 latch inst, go DECODE; else stay.
REQ-019 DECODE: one cycle; classify opcode; imm_sel valid from DECODE through last state of the instruction.
REQ-020 EXEC transitions: OP/OP-IMM/LUI/AUIPC/JAL/JALR -> WB; LOAD/STORE -> MEM; BRANCH -> FETCH.
REQ-021 Branch in EXEC: pc_sel=1 and pc_wen=1 iff condition true (BEQ br_eq, BNE !br_eq, BLT br_lt, BGE !br_lt; unsigned variants use same inputs); otherwise pc_wen=1, pc_sel=0.
REQ-022 MEM: mem_req=1, mem_rw=1 for STORE, 0 for LOAD; held stable until mem_ready; on mem_ready LOAD -> WB, STORE -> FETCH with pc_wen=1.
REQ-023 MEM wait counter counts cycles with mem_ready=0; reaching MEM_WAIT_MAX pulses mem_err, drops mem_req, goes FETCH without PC update; mem_ready in the same cycle wins over timeout.
REQ-024 WB: reg_wen=1 for exactly one cycle unless rd=0 (reg_wen=0); pc_wen=1; pc_sel=1 for JAL/JALR; next FETCH.
REQ-025 Latency inst handshake to retire: branch 3, ALU/U/J 4, store 4+wait, load 5+wait cycles.
REQ-026 Unrecognised opcode handled per REQ-031/032.

Reset
REQ-027 rst_n=0 forces state FETCH, instruction register 0, wait counter 0, illegal 0, asynchronously.
REQ-028 During reset all outputs 0 except inst_ready=0 until first clock after deassertion; imm_sel=000.
REQ-029 Reset mid-MEM drops mem_req immediately; no write or PC update completes.

Configuration
REQ-030 Macro MC_ILLEGAL_TRAP_EN selects illegal-opcode handling.
REQ-031 Defined: illegal opcode in DECODE -> TRAP; illegal=1; all enables 0; TRAP held until reset.
REQ-032 Undefined: illegal opcode executes as NOP (DECODE -> FETCH with pc_wen=1); illegal tied 0; TRAP state absent.

Structure
REQ-033 Package mc_pkg holds opcode constants, imm_sel encodings, alu_sel encodings, wb_sel encodings, state enumeration.
REQ-034 Sub-module mc_decode: combinational opcode/funct3/funct7 classifier producing instruction class, imm_sel, alu_sel; FSM lives in mc_control.

Verification
REQ-035 addi x1,x0,5 (0x00500093) -> imm_sel=000, b_sel=1, wb_sel=01, reg_wen=1 only in cycle 4 after handshake.
REQ-036 sw x1,4(x2) (0x00112223), mem_ready after 3 wait cycles -> imm_sel=001, mem_req=1,mem_rw=1 held 4 cycles, reg_wen never 1.
REQ-037 beq x0,x0,+8 (0x00000463), br_eq=1 -> imm_sel=010, pc_sel=1,pc_wen=1 in EXEC, back in FETCH next cycle; br_eq=0 -> pc_sel=0.
REQ-038 lw with mem_ready held 0 -> mem_err pulse after 16 cycles, mem_req 0, reg_wen never 1, FETCH next.
REQ-039 inst 0x00000000 with MC_ILLEGAL_TRAP_EN -> illegal=1 and held, inst_ready 0 forever; without macro -> pc_wen pulse, next FETCH.
REQ-040 rst_n low during MEM -> mem_req 0 same cycle, state FETCH, imm_sel=000 after release.
